// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared constants, FSM state enum and BCD digit type for the stopwatch display path
package stopwatch_pkg;
    localparam int BIN_W    = 20;
    localparam int DIGITS   = 6;
    localparam int MAX_DISP = 999999;
    typedef enum logic [1:0] {IDLE, CONVERT, FINISH} state_t;
    typedef logic [3:0] digit_t;
endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: double-dabble nibble correction, adds 3 when the nibble is 5 or more
module bcd_add3
    import stopwatch_pkg::*;
(
    input  logic [3:0] d,
    output logic [3:0] q
);
    digit_t n;
    assign n = d;
    assign q = (n >= 4'd5) ? n + 4'd3 : n;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, fixed 21-cycle latency, saturating at 999999
module bin2bcd_seq
    import stopwatch_pkg::*;
#(
    parameter int BIN_W  = 20,
    parameter int DIGITS = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [3:0]       ones,
    output logic [3:0]       tens,
    output logic [3:0]       hundreds,
    output logic [3:0]       thousands,
    output logic [3:0]       ten_thousands,
    output logic [3:0]       hun_thousands,
    output logic             ovf
);
    localparam int NIB  = DIGITS + 1;
    localparam int CW   = $clog2(BIN_W + 1);
    state_t            state, state_n;
    logic [BIN_W-1:0]  bin_sr;
    logic [NIB*4-1:0]  bcd, adj;
    logic [CW-1:0]     cnt;
    logic              last, sat;
    genvar i;
    for (i = 0; i < NIB; i++) begin : g_add3
        bcd_add3 u_add3 (.d(bcd[i*4 +: 4]), .q(adj[i*4 +: 4]));
    end
    assign last = cnt == CW'(BIN_W - 1);
    assign sat  = |bcd[NIB*4-1:DIGITS*4];
    assign busy = state != IDLE;
    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end
    // next state: accept start only when idle, leave CONVERT after the last step
    always_comb begin
        state_n = state;
        state_n = (state == IDLE)    ? (start ? CONVERT : IDLE) :
                  (state == CONVERT) ? (last ? FINISH : CONVERT) : IDLE;
    end
    // datapath: capture, shift-and-correct, then publish the saturated digits
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_sr        <= '0;
            bcd           <= '0;
            cnt           <= '0;
            done          <= 1'b0;
            ovf           <= 1'b0;
            ones          <= '0;
            tens          <= '0;
            hundreds      <= '0;
            thousands     <= '0;
            ten_thousands <= '0;
            hun_thousands <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE && start) begin
                bin_sr <= bin;
                bcd    <= '0;
                cnt    <= '0;
            end else if (state == CONVERT) begin
                {bcd, bin_sr} <= {adj, bin_sr} << 1;
                cnt           <= cnt + 1'b1;
            end else if (state == FINISH) begin
                done          <= 1'b1;
                ovf           <= sat;
                ones          <= sat ? 4'd9 : bcd[3:0];
                tens          <= sat ? 4'd9 : bcd[7:4];
                hundreds      <= sat ? 4'd9 : bcd[11:8];
                thousands     <= sat ? 4'd9 : bcd[15:12];
                ten_thousands <= sat ? 4'd9 : bcd[19:16];
                hun_thousands <= sat ? 4'd9 : bcd[23:20];
            end
        end
    end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: scoreboard bench for bin2bcd_seq with directed vectors
module tb_bin2bcd_seq;
    typedef struct {
        logic [23:0] dig;
        logic        ovf;
        int          at;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, start, busy, done, ovf;
    logic [19:0] bin;
    logic [3:0]  ones, tens, hundreds, thousands, ten_thousands, hun_thousands;
    logic [23:0] dig;
    exp_t        q[$];
    int          cyc = 0, cmp = 0, bad = 0, dones = 0;

    bin2bcd_seq #(.BIN_W(20), .DIGITS(6)) dut (
        .clk(clk), .rst(rst), .start(start), .bin(bin), .busy(busy), .done(done),
        .ones(ones), .tens(tens), .hundreds(hundreds), .thousands(thousands),
        .ten_thousands(ten_thousands), .hun_thousands(hun_thousands), .ovf(ovf)
    );

    assign dig = {hun_thousands, ten_thousands, thousands, hundreds, tens, ones};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            dones++;
            if (q.size() == 0) check("spurious_done", 32'(done), 32'd0);
            else begin
                exp_t e;
                e = q.pop_front();
                check("digits", 32'(dig), 32'(e.dig));
                check("ovf", 32'(ovf), 32'(e.ovf));
                check("latency", cyc, e.at);
                check("busy_in_done", 32'(busy), 32'd0);
            end
        end
    end

    task automatic issue(input logic [19:0] v, input logic [23:0] d, input logic o, input bit push);
        @(negedge clk);
        bin   = v;
        start = 1'b1;
        if (push) q.push_back('{dig: d, ovf: o, at: cyc + 1 + 21});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && q.size() > 0; i++) @(negedge clk);
        check("drain_timeout", q.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        int n, d0, a;
        rst = 1'b1; start = 1'b0; bin = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_digits", 32'(dig), 0);
        check("rst_ovf", 32'(ovf), 0);
        rst = 1'b0;

        issue(20'd0, 24'h000000, 1'b0, 1'b1);
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("busy_cycles", n, 21);
        drain();

        issue(20'd123456, 24'h123456, 1'b0, 1'b1); drain();
        issue(20'd999999, 24'h999999, 1'b0, 1'b1); drain();
        issue(20'd1048575, 24'h999999, 1'b1, 1'b1); drain();
        issue(20'd1000000, 24'h999999, 1'b1, 1'b1); drain();
        issue(20'd100, 24'h000100, 1'b0, 1'b1); drain();
        check("hold_digits", 32'(dig), 32'h000100);

        d0 = dones;
        issue(20'd42, 24'h000042, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        bin = 20'd777; start = 1'b1;
        @(negedge clk);
        start = 1'b0; bin = 20'd555;
        drain();
        repeat (30) @(negedge clk);
        check("single_done", dones - d0, 1);

        d0 = dones;
        issue(20'd500000, 24'h500000, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_digits", 32'(dig), 0);
        check("abort_ovf", 32'(ovf), 0);
        repeat (30) @(negedge clk);
        check("abort_no_done", dones - d0, 0);
        issue(20'd31, 24'h000031, 1'b0, 1'b1); drain();

        @(negedge clk);
        a = cyc + 1;
        bin = 20'd1; start = 1'b1;
        q.push_back('{dig: 24'h000001, ovf: 1'b0, at: a + 21});
        q.push_back('{dig: 24'h000002, ovf: 1'b0, at: a + 43});
        q.push_back('{dig: 24'h000003, ovf: 1'b0, at: a + 65});
        @(negedge clk);
        bin = 20'd2;
        repeat (22) @(negedge clk);
        bin = 20'd3;
        repeat (22) @(negedge clk);
        start = 1'b0;
        drain();
        repeat (25) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule
